// File: rtl/nibble_add_seq.sv
// nibble_add_seq: WIDTH-bit add via one shared 4-bit adder, one nibble per clock, LSB first.
// Optional subtract mode (a-b, cout=1 means no borrow) is enabled by defining NIBBLE_ADD_SEQ_SUB_EN.
module nibble_add_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef NIBBLE_ADD_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_sum,
  input  logic             add_cout
);
  localparam int NSLICE = WIDTH / 4;
  localparam int KW = NSLICE > 1 ? $clog2(NSLICE) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] a_r, b_r;
  logic carry_r, sub_r, sub_in, accept, last;
  logic [KW-1:0] k;
  generate
    if (WIDTH < 4 || WIDTH % 4 != 0) begin : g_bad_width
      $error("nibble_add_seq: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate
`ifdef NIBBLE_ADD_SEQ_SUB_EN
  assign sub_in = sub;
`else
  assign sub_in = 1'b0;
`endif
  assign accept = start && state != RUN;
  assign last = k == KW'(NSLICE - 1);
  assign busy = state == RUN;
  assign done = state == DONE;
  // Subtraction is a + ~b + 1: invert the b slice, seed carry with 1.
  assign add_a = busy ? a_r[{k, 2'b00} +: 4] : 4'd0;
  assign add_b = busy ? b_r[{k, 2'b00} +: 4] ^ {4{sub_r}} : 4'd0;
  assign add_cin = busy & carry_r;
  always_comb begin
    state_nx = IDLE;
    if (accept) state_nx = RUN;
    else if (state == RUN) state_nx = last ? DONE : RUN;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r <= '0;
      b_r <= '0;
      carry_r <= 1'b0;
      sub_r <= 1'b0;
      k <= '0;
      sum <= '0;
      cout <= 1'b0;
    end else if (accept) begin
      a_r <= a;
      b_r <= b;
      sub_r <= sub_in;
      carry_r <= sub_in | cin;
      k <= '0;
    end else if (state == RUN) begin
      sum[{k, 2'b00} +: 4] <= add_sum;
      carry_r <= add_cout;
      k <= k + 1'b1;
      if (last) cout <= add_cout;
    end
  end
endmodule

// File: tb/tb_nibble_add_seq.sv
// tb_nibble_add_seq: directed test of nibble_add_seq (WIDTH=16) with a golden 4-bit adder and a result/timing model.
module tb_nibble_add_seq;
  localparam int W = 16;
  localparam int NS = W / 4;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, cin = 1'b0, sb = 1'b0;
  logic [W-1:0] a = '0, b = '0, sum;
  logic busy, done, cout, add_cin, add_cout;
  logic [3:0] add_a, add_b, add_sum;
  int total = 0, passed = 0;
  always #5 clk = ~clk;
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};
  nibble_add_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
`ifdef NIBBLE_ADD_SEQ_SUB_EN
    .sub(sb),
`endif
    .busy(busy), .done(done), .sum(sum), .cout(cout),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  // Model: remaining RUN edges, pending full-width result, and visible outputs.
  int phase;
  logic [W:0] res;
  logic [W-1:0] exp_sum;
  logic exp_cout, exp_done;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      phase = 0; exp_sum = '0; exp_cout = 1'b0; exp_done = 1'b0; res = '0;
    end else if (phase > 0) begin
      phase--;
      if (phase == 0) begin
        exp_done = 1'b1; exp_sum = res[W-1:0]; exp_cout = res[W];
      end
    end else begin
      exp_done = 1'b0;
      if (start) begin
        phase = NS;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
        res = sb ? {1'b0, a} + {1'b0, ~b} + 1'b1 : {1'b0, a} + {1'b0, b} + cin;
`else
        res = {1'b0, a} + {1'b0, b} + cin;
`endif
      end
    end
  end
  always @(negedge clk) if (!rst) begin
    chk("busy", busy, phase > 0);
    chk("done", done, exp_done);
    chk("cout", cout, exp_cout);
    if (phase == 0) begin
      chk("sum", sum, exp_sum);
      chk("adder_idle", {add_a, add_b, add_cin}, 0);
    end
  end
  task automatic wait_done(input string nm);
    int n = 0;
    while (!done && n < 20) begin @(negedge clk); n++; end
    if (!done) chk({nm, "_timeout"}, 0, 1);
  endtask
  task automatic op(input logic [W-1:0] ai, bi, input logic ci, s, input logic [W-1:0] es, input logic ec, input string nm);
    a = ai; b = bi; cin = ci; sb = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(nm);
    chk({nm, "_sum"}, sum, es);
    chk({nm, "_cout"}, cout, ec);
    @(negedge clk);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_sum", sum, 0);
    chk("rst_flags", {busy, done, cout}, 0);
    chk("rst_adder", {add_a, add_b, add_cin}, 0);
    op(16'h1234, 16'h0FFF, 0, 0, 16'h2233, 0, "t1");
    op(16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, "ripple");
    op(16'h0000, 16'h0000, 1, 0, 16'h0001, 0, "cin_only");
    // start held through RUN with changing operands; re-accepted in DONE
    a = 16'h1111; b = 16'h2222; cin = 0; sb = 0; start = 1'b1;
    @(negedge clk);
    a = 16'h5555; b = 16'h1111;
    wait_done("hold1");
    chk("hold1_sum", sum, 16'h3333);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", busy, 1);
    wait_done("hold2");
    chk("hold2_sum", sum, 16'h6666);
    @(negedge clk);
    // async reset mid-RUN, between E2 and E3
    a = 16'hABCD; b = 16'h1357; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    #1 chk("mid_rst_sum", sum, 0);
    chk("mid_rst_flags", {busy, done, cout}, 0);
    #1 rst = 1'b0;
    begin
      int seen = 0;
      repeat (8) begin @(negedge clk); if (done) seen++; end
      chk("no_done_after_rst", seen, 0);
    end
    op(16'h0101, 16'h0202, 0, 0, 16'h0303, 0, "post_rst");
`ifdef NIBBLE_ADD_SEQ_SUB_EN
    op(16'h0005, 16'h0007, 1, 1, 16'hFFFE, 0, "sub_borrow");
    op(16'h0009, 16'h0004, 0, 1, 16'h0005, 1, "sub_ok");
    op(16'h0009, 16'h0004, 1, 0, 16'h000E, 0, "sub_off");
`endif
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
